// File: rtl/peak_detect_pkg.sv
// -----------------------------------------------------------------------------
// peak_detect_pkg
//   Shared widths, peak-report bit positions and the input-FSM state type for
//   the per-channel peak detector.
//
//   Report word layout (64 bits):
//     [31:0]                       peak value
//     [32 +: INDEX_WIDTH]          peak bin
//     [62:32+INDEX_WIDTH]          zero
//     [63]                         found
// -----------------------------------------------------------------------------
package peak_detect_pkg;

  // Default widths. A 1024-point FFT gives a 10-bit bin index.
  localparam int DATA_WIDTH_DEF  = 32;
  localparam int INDEX_WIDTH_DEF = 10;

  // Peak report layout.
  localparam int REPORT_WIDTH   = 64;
  localparam int PEAK_VALUE_LSB = 0;
  localparam int PEAK_BIN_LSB   = 32;
  localparam int PEAK_FOUND_BIT = 63;

  // Status counter widths.
  localparam int FRAME_COUNT_WIDTH    = 16;
  localparam int OVERFLOW_COUNT_WIDTH = 8;

  // Input framing state: IDLE means no beat of the current frame seen yet.
  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } in_state_t;

endpackage

// File: rtl/peak_detect_tracker.sv
// -----------------------------------------------------------------------------
// peak_detect_tracker
//   Running maximum over one frame of power values. A beat is a candidate when
//   its bin is at or above MIN_BIN, its value is strictly above the threshold,
//   and it strictly beats the current maximum (or nothing has been found yet),
//   so the earliest bin wins a tie. The tracker clears on the frame-closing
//   beat.
//
//   The peak_* outputs are the tracker contents *including* the current beat's
//   candidacy, which is exactly what the frame-close report needs.
//
// Ports
//   clk, rstn       clock, asynchronous active-low reset
//   beat            accepted input beat
//   close           accepted beat that also carries tlast
//   data            power value of the beat
//   index           bin index of the beat
//   threshold       candidacy threshold, sampled with the beat
//   peak_found      a candidate has been seen this frame (incl. current beat)
//   peak_value      largest candidate value (0 if none)
//   peak_bin        bin of the largest candidate (0 if none)
// -----------------------------------------------------------------------------
module peak_detect_tracker
  import peak_detect_pkg::*;
#(
  parameter int          DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int          INDEX_WIDTH = INDEX_WIDTH_DEF,
  parameter int unsigned MIN_BIN     = 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   beat,
  input  logic                   close,
  input  logic [DATA_WIDTH-1:0]  data,
  input  logic [INDEX_WIDTH-1:0] index,
  input  logic [DATA_WIDTH-1:0]  threshold,
  output logic                   peak_found,
  output logic [DATA_WIDTH-1:0]  peak_value,
  output logic [INDEX_WIDTH-1:0] peak_bin
);

  logic                   found_r;
  logic [DATA_WIDTH-1:0]  max_r;
  logic [INDEX_WIDTH-1:0] bin_r;
  logic                   candidate;

  // NOTE: every output of a combinational block is given a value at the top
  // of the block so no path through it can leave a latch behind.
  always_comb begin
    candidate  = 1'b0;
    peak_found = found_r;
    peak_value = max_r;
    peak_bin   = bin_r;

    if (beat &&
        (index >= INDEX_WIDTH'(MIN_BIN)) &&
        (data > threshold) &&
        (!found_r || (data > max_r))) begin
      candidate = 1'b1;
    end

    if (candidate) begin
      peak_found = 1'b1;
      peak_value = data;
      peak_bin   = index;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      found_r <= 1'b0;
      max_r   <= '0;
      bin_r   <= '0;
    end else if (close) begin
      // The closing beat's candidacy is already folded into peak_*; the
      // next frame starts from a clean tracker.
      found_r <= 1'b0;
      max_r   <= '0;
      bin_r   <= '0;
    end else if (candidate) begin
      found_r <= 1'b1;
      max_r   <= data;
      bin_r   <= index;
    end
  end

endmodule

// File: rtl/peak_detect.sv
// -----------------------------------------------------------------------------
// peak_detect
//   Per-channel peak detector. Consumes one frame of power values (tlast
//   closes the frame, xk_in is the bin of each beat), finds the largest value
//   strictly above a threshold, and posts a 64-bit report on a one-deep
//   buffered AXI-Stream master one cycle after the closing beat. A report that
//   is still unread when the next one arrives is overwritten and counted.
//
// Ports
//   clk              processing clock
//   rstn             asynchronous active-low reset
//   threshold        peak threshold, sampled on every accepted beat
//   s_axis_tdata     power value
//   s_axis_tvalid    beat valid (every valid beat is accepted)
//   s_axis_tready    constant 1, the power stage has no backpressure
//   s_axis_tlast     last bin of the frame
//   xk_in            bin index aligned with s_axis_tdata
//   m_axis_tdata     peak report {found, zero, bin, value}
//   m_axis_tvalid    report available
//   m_axis_tready    collector accepts the report
//   frame_count      frames closed, wraps
//   overflow_count   reports overwritten before being read, saturates
// -----------------------------------------------------------------------------
module peak_detect
  import peak_detect_pkg::*;
#(
  // The value field of the report is 32 bits wide; DATA_WIDTH must not
  // exceed it.
  parameter int          DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int          INDEX_WIDTH = INDEX_WIDTH_DEF,
  parameter int unsigned MIN_BIN     = 1
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [DATA_WIDTH-1:0]           threshold,
  input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  input  logic [INDEX_WIDTH-1:0]          xk_in,
  output logic [REPORT_WIDTH-1:0]         m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [FRAME_COUNT_WIDTH-1:0]    frame_count,
  output logic [OVERFLOW_COUNT_WIDTH-1:0] overflow_count
);

  localparam logic [OVERFLOW_COUNT_WIDTH-1:0] OVERFLOW_MAX = '1;

  // ---------------------------------------------------------------------------
  // Beat qualification
  // ---------------------------------------------------------------------------
  logic beat;
  logic close;

  assign s_axis_tready = 1'b1;
  assign beat          = s_axis_tvalid;
  // tlast without tvalid carries no bin and is ignored.
  assign close         = s_axis_tvalid & s_axis_tlast;

  // ---------------------------------------------------------------------------
  // Input framing FSM
  // ---------------------------------------------------------------------------
  in_state_t state_q;
  in_state_t state_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        // A single-beat frame opens and closes in the same cycle.
        if (beat && !s_axis_tlast) begin
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (close) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Peak tracker
  // ---------------------------------------------------------------------------
  logic                   peak_found;
  logic [DATA_WIDTH-1:0]  peak_value;
  logic [INDEX_WIDTH-1:0] peak_bin;

  peak_detect_tracker #(
    .DATA_WIDTH  (DATA_WIDTH),
    .INDEX_WIDTH (INDEX_WIDTH),
    .MIN_BIN     (MIN_BIN)
  ) u_tracker (
    .clk        (clk),
    .rstn       (rstn),
    .beat       (beat),
    .close      (close),
    .data       (s_axis_tdata),
    .index      (xk_in),
    .threshold  (threshold),
    .peak_found (peak_found),
    .peak_value (peak_value),
    .peak_bin   (peak_bin)
  );

  // ---------------------------------------------------------------------------
  // Report assembly. With no candidate the tracker still holds value 0 and
  // bin 0, so the "no peak" report falls out without a special case.
  // ---------------------------------------------------------------------------
  logic [REPORT_WIDTH-1:0] report;

  always_comb begin
    report                                  = '0;
    report[PEAK_VALUE_LSB +: DATA_WIDTH]    = peak_value;
    report[PEAK_BIN_LSB +: INDEX_WIDTH]     = peak_bin;
    report[PEAK_FOUND_BIT]                  = peak_found;
  end

  // ---------------------------------------------------------------------------
  // One-deep output buffer and status counters
  // ---------------------------------------------------------------------------
  logic handshake;
  logic stalled;

  assign handshake = m_axis_tvalid &  m_axis_tready;
  // A held report that the collector is not taking this cycle is lost if a
  // new one loads now.
  assign stalled   = m_axis_tvalid & ~m_axis_tready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_axis_tdata   <= '0;
      m_axis_tvalid  <= 1'b0;
      frame_count    <= '0;
      overflow_count <= '0;
    end else begin
      if (close) begin
        m_axis_tdata  <= report;
        m_axis_tvalid <= 1'b1;
        frame_count   <= frame_count + 1'b1;
        if (stalled && (overflow_count != OVERFLOW_MAX)) begin
          overflow_count <= overflow_count + 1'b1;
        end
      end else if (handshake) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_peak_detect.sv
// -----------------------------------------------------------------------------
// tb_peak_detect
//   Self-checking bench for peak_detect. Stimulus is applied one cycle at a
//   time; after each edge a frame-level reference model decides which report
//   the DUT should now hold and pushes it onto a scoreboard. A monitor on the
//   falling edge compares the DUT's outputs against the scoreboard head and
//   the model's counters, and pops the head on every handshake.
// -----------------------------------------------------------------------------
module tb_peak_detect;
  import peak_detect_pkg::*;

  localparam int DW      = 32;
  localparam int IW      = INDEX_WIDTH_DEF;
  localparam int MIN_BIN = 1;

  logic            clk;
  logic            rstn;
  logic [DW-1:0]   threshold;
  logic [DW-1:0]   s_axis_tdata;
  logic            s_axis_tvalid;
  logic            s_axis_tready;
  logic            s_axis_tlast;
  logic [IW-1:0]   xk_in;
  logic [63:0]     m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic [15:0]     frame_count;
  logic [7:0]      overflow_count;

  peak_detect #(
    .DATA_WIDTH  (DW),
    .INDEX_WIDTH (IW),
    .MIN_BIN     (MIN_BIN)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .threshold      (threshold),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tlast   (s_axis_tlast),
    .xk_in          (xk_in),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .frame_count    (frame_count),
    .overflow_count (overflow_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [DW-1:0] data;
    logic [IW-1:0] idx;
    logic [DW-1:0] thr;
  } beat_t;

  beat_t        frame_q[$];   // beats of the frame in progress
  logic [63:0]  sb_q[$];      // reports the DUT still has to present
  logic         exp_valid;
  logic [15:0]  exp_frames;
  logic [7:0]   exp_ovf;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mk(input logic found, input logic [IW-1:0] bin,
                                     input logic [31:0] value);
    logic [63:0] r;
    r            = '0;
    r[31:0]      = value;
    r[32 +: IW]  = bin;
    r[63]        = found;
    return r;
  endfunction

  // Peak of the collected frame: the largest eligible value, reported at the
  // first bin that carries it.
  function automatic logic [63:0] ref_report();
    logic [DW-1:0] best;
    logic [IW-1:0] bin;
    bit            any;
    best = '0;
    bin  = '0;
    any  = 0;
    foreach (frame_q[i]) begin
      if (frame_q[i].idx >= IW'(MIN_BIN) && frame_q[i].data > frame_q[i].thr) begin
        if (!any || frame_q[i].data > best) best = frame_q[i].data;
        any = 1;
      end
    end
    if (any) begin
      for (int i = 0; i < frame_q.size(); i++) begin
        if (frame_q[i].idx >= IW'(MIN_BIN) && frame_q[i].data > frame_q[i].thr &&
            frame_q[i].data == best) begin
          bin = frame_q[i].idx;
          break;
        end
      end
    end
    return mk(any, bin, best);
  endfunction

  task automatic model_reset();
    frame_q.delete();
    sb_q.delete();
    exp_valid  = 1'b0;
    exp_frames = '0;
    exp_ovf    = '0;
  endtask

  // Apply one cycle of stimulus, let the edge happen, then advance the model.
  task automatic step(input logic v, input logic l, input logic [DW-1:0] d,
                      input logic [IW-1:0] x, input logic [DW-1:0] thr, input logic rdy);
    logic hs;
    s_axis_tvalid = v;
    s_axis_tlast  = l;
    s_axis_tdata  = d;
    xk_in         = x;
    threshold     = thr;
    m_axis_tready = rdy;
    @(posedge clk);
    #1;
    hs = exp_valid && rdy;
    if (v) frame_q.push_back('{data: d, idx: x, thr: thr});
    if (v && l) begin
      if (exp_valid && !rdy) begin
        if (sb_q.size() > 0) void'(sb_q.pop_back());
        if (exp_ovf != 8'd255) exp_ovf++;
      end
      sb_q.push_back(ref_report());
      frame_q.delete();
      exp_frames++;
      exp_valid = 1'b1;
    end else if (hs) begin
      exp_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, threshold, rdy);
  endtask

  task automatic do_reset();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    rstn          = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    check("s_axis_tready", 64'(s_axis_tready), 64'd1);
    check("m_axis_tvalid", 64'(m_axis_tvalid), 64'(exp_valid));
    check("frame_count", 64'(frame_count), 64'(exp_frames));
    check("overflow_count", 64'(overflow_count), 64'(exp_ovf));
    if (!rstn) check("reset_tdata", m_axis_tdata, 64'd0);
    if (m_axis_tvalid) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL report_unexpected: got 0x%0h expected no report at %0t",
                 m_axis_tdata, $time);
      end else begin
        check("report", m_axis_tdata, sb_q[0]);
        if (m_axis_tready) void'(sb_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [DW-1:0] tp1_vals [8] = '{32'd0, 32'd50, 32'd300, 32'd120, 32'd900, 32'd10, 32'd900, 32'd5};
  logic [DW-1:0] tp2_vals [8] = '{32'd5000, 32'd1000, 32'd999, 32'd0, 32'd1000, 32'd3, 32'd700, 32'd1000};

  initial begin
    rstn          = 1'b0;
    threshold     = '0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    xk_in         = '0;
    m_axis_tready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    // Single peak: tie at 900 goes to the earlier bin 4.
    for (int i = 0; i < 8; i++) step(1'b1, i == 7, tp1_vals[i], IW'(i), 32'd100, 1'b1);
    check("tp1_report", m_axis_tdata, mk(1'b1, 10'd4, 32'd900));
    check("tp1_valid", 64'(m_axis_tvalid), 64'd1);
    check("tp1_frames", 64'(frame_count), 64'd1);
    idle(2, 1'b1);

    // DC bin above threshold is excluded; nothing else beats 1000.
    for (int i = 0; i < 8; i++) step(1'b1, i == 7, tp2_vals[i], IW'(i), 32'd1000, 1'b1);
    check("tp2_report", m_axis_tdata, mk(1'b0, 10'd0, 32'd0));
    check("tp2_valid", 64'(m_axis_tvalid), 64'd1);
    idle(2, 1'b1);

    // Backpressure: three frames while the collector stalls.
    for (int f = 1; f <= 3; f++) begin
      step(1'b1, 1'b0, 32'd0,          10'd0, 32'd0, 1'b0);
      step(1'b1, 1'b0, DW'(10 * f),    10'd1, 32'd0, 1'b0);
      step(1'b1, 1'b0, DW'(f),         10'd2, 32'd0, 1'b0);
      step(1'b1, 1'b1, DW'(2 * f - 1), 10'd3, 32'd0, 1'b0);
    end
    check("tp3_report", m_axis_tdata, mk(1'b1, 10'd1, 32'd30));
    check("tp3_overflow", 64'(overflow_count), 64'd2);
    idle(1, 1'b1);
    idle(1, 1'b0);
    check("tp3_consumed_one", 64'(m_axis_tvalid), 64'd0);

    // Consume and load on the same edge: no overflow.
    step(1'b1, 1'b0, 32'd0,  10'd0, 32'd0, 1'b0);
    step(1'b1, 1'b1, 32'd15, 10'd1, 32'd0, 1'b0);
    step(1'b1, 1'b0, 32'd0,  10'd0, 32'd0, 1'b0);
    step(1'b1, 1'b1, 32'd25, 10'd1, 32'd0, 1'b1);
    check("tp4_report", m_axis_tdata, mk(1'b1, 10'd1, 32'd25));
    check("tp4_overflow", 64'(overflow_count), 64'd2);
    idle(2, 1'b1);

    // Reset mid-frame: the partial frame never reports.
    do_reset();
    step(1'b1, 1'b0, 32'd100, 10'd0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'd200, 10'd1, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'd300, 10'd2, 32'd0, 1'b1);
    do_reset();
    step(1'b1, 1'b0, 32'd0, 10'd0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'd5, 10'd1, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'd9, 10'd2, 32'd0, 1'b1);
    step(1'b1, 1'b1, 32'd3, 10'd3, 32'd0, 1'b1);
    check("tp6_report", m_axis_tdata, mk(1'b1, 10'd2, 32'd9));
    check("tp6_frames", 64'(frame_count), 64'd1);
    check("tp6_overflow", 64'(overflow_count), 64'd0);
    idle(3, 1'b1);

    // Single-beat frame followed back-to-back by a two-beat frame.
    do_reset();
    step(1'b1, 1'b1, 32'd7, 10'd3, 32'd0, 1'b1);
    check("tp5_first", m_axis_tdata, mk(1'b1, 10'd3, 32'd7));
    step(1'b1, 1'b0, 32'd50, 10'd0, 32'd0, 1'b1);
    step(1'b1, 1'b1, 32'd9,  10'd1, 32'd0, 1'b1);
    check("tp5_second", m_axis_tdata, mk(1'b1, 10'd1, 32'd9));
    check("tp5_frames", 64'(frame_count), 64'd2);
    idle(2, 1'b1);

    // Randomized frames with gaps, stray tlast, ties and stalls.
    begin
      logic [IW-1:0] bin;
      logic [DW-1:0] thr;
      bin = '0;
      thr = 32'd20;
      for (int i = 0; i < 4000; i++) begin
        logic v, l, rdy;
        logic [DW-1:0] d;
        v   = ($urandom_range(3) != 0);
        l   = ($urandom_range(5) == 0);
        rdy = ($urandom_range(2) != 0);
        d   = ($urandom_range(7) == 0) ? DW'($urandom) : DW'($urandom_range(63));
        step(v, l, d, bin, thr, rdy);
        if (v) begin
          bin = l ? '0 : bin + 1'b1;
          if (l) thr = DW'($urandom_range(40));
        end
      end
    end

    // Drain.
    idle(4, 1'b1);
    check("drain_valid", 64'(m_axis_tvalid), 64'd0);
    check("drain_scoreboard", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
